// File: rtl/cpu_pkg.sv
// Shared datapath constants and routing select encodings for the
// writeback demultiplexer and its channel FIFOs.
package cpu_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned CNT_W      = 8;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_e;

endpackage

// File: rtl/route_fifo2.sv
// Two-entry channel FIFO with registered head word, fill level and a
// wrapping count of completed output transfers.
module route_fifo2
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [1:0]       fill_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       fill_q, fill_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       wr_idx;
    logic             push;
    logic             pop;

    assign full_o  = (fill_q == 2'(DEPTH));
    assign empty_o = (fill_q == 2'd0);
    assign valid_o = !empty_o;
    assign data_o  = head_q;
    assign fill_o  = fill_q;
    assign count_o = count_q;

    assign pop    = valid_o && ready_i;
    assign push   = push_i && !full_o;
    assign wr_idx = fill_q - {1'b0, pop};

    // Pop shifts the tail forward first; the push slot is then the post-pop fill.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        fill_d  = fill_q + {1'b0, push} - {1'b0, pop};
        count_d = count_q + CNT_W'(pop);
        if (pop) begin
            head_d = tail_q;
        end
        if (push) begin
            if (wr_idx == 2'd0) begin
                head_d = din_i;
            end else begin
                tail_d = din_i;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            fill_q  <= fill_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/demux_1_to_2_buf.sv
// Buffered 1-to-2 demultiplexer: steers one producer stream into two
// independent 2-entry channel FIFOs selected by in_sel.
module demux_1_to_2_buf
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic [CNT_W-1:0] a_count,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [CNT_W-1:0] b_count
);

    sel_e       sel;
    logic       full_a, full_b;
    logic       empty_a, empty_b;
    logic [1:0] fill_a, fill_b;
    logic       push_a, push_b;
    logic       xfer;

    assign sel = sel_e'(in_sel);

    // Readiness looks only at the selected channel's registered fill.
    always_comb begin
        in_ready = 1'b0;
        if (reset) begin
            in_ready = (sel == SEL_B) ? !full_b : !full_a;
        end
    end

    assign xfer   = in_valid && in_ready;
    assign push_a = xfer && (sel == SEL_A);
    assign push_b = xfer && (sel == SEL_B);

    route_fifo2 #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .CLK     (CLK),
        .reset   (reset),
        .push_i  (push_a),
        .din_i   (in_data),
        .ready_i (a_ready),
        .valid_o (a_valid),
        .data_o  (a_data),
        .full_o  (full_a),
        .empty_o (empty_a),
        .fill_o  (fill_a),
        .count_o (a_count)
    );

    route_fifo2 #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .CLK     (CLK),
        .reset   (reset),
        .push_i  (push_b),
        .din_i   (in_data),
        .ready_i (b_ready),
        .valid_o (b_valid),
        .data_o  (b_data),
        .full_o  (full_b),
        .empty_o (empty_b),
        .fill_o  (fill_b),
        .count_o (b_count)
    );

    // Status taps kept for debug visibility; routing needs only full flags.
    logic unused_status;
    assign unused_status = ^{empty_a, empty_b, fill_a, fill_b};

endmodule
